// File: rtl/csr_file_m.sv
// rtl/csr_file_m.sv - machine-mode CSR file with trap/mret sequencing, interrupt gating and 64-bit counters
module csr_file_m #(
    parameter int              XLEN         = 32,
    parameter int              HAS_COUNTERS = 1,
    parameter logic [XLEN-1:0] MTVEC_RESET  = '0,
    parameter int              VECTORED_EN  = 1
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic [11:0]     csr_addr,
    input  logic [1:0]      csr_op,
    input  logic [XLEN-1:0] csr_w_data,
    output logic [XLEN-1:0] csr_r_data,
    output logic            csr_illegal,
    input  logic            instr_retire,
    input  logic            trap_en,
    input  logic [XLEN-1:0] trap_cause,
    input  logic [XLEN-1:0] trap_pc,
    input  logic [XLEN-1:0] trap_val,
    input  logic            mret_en,
    input  logic            irq_ext,
    input  logic            irq_timer,
    input  logic            irq_soft,
    output logic [XLEN-1:0] trap_vector,
    output logic [XLEN-1:0] mepc_out,
    output logic            irq_pending
);
    localparam logic [1:0]      OP_RW    = 2'b01;
    localparam logic [1:0]      OP_RS    = 2'b10;
    localparam logic [1:0]      OP_RC    = 2'b11;
    localparam logic [XLEN-1:0] MISA     = 32'h4000_0100;
    localparam logic [XLEN-1:0] MIE_MASK = 32'h0000_0888;
    localparam logic            CNT_EN   = (HAS_COUNTERS != 0);
    localparam logic            VEC_EN   = (VECTORED_EN != 0);
    localparam logic            RST_MODE = (MTVEC_RESET[1:0] == 2'b01) && VEC_EN;

    logic            mstatus_mie, mstatus_mpie;
    logic [XLEN-1:0] mie_reg, mscratch, mepc, mcause, mtval;
    logic [XLEN-3:0] mtvec_base;
    logic            mtvec_mode;
    logic [2:0]      mip_q;
    logic [63:0]     mcycle, minstret, mcycle_next, minstret_next;

    logic [XLEN-1:0] mstatus_val, mip_val, rd_val, wr_val;
    logic            hit, read_only, wr_en;

    always_comb begin
        mstatus_val        = '0;
        mstatus_val[12:11] = 2'b11;
        mstatus_val[7]     = mstatus_mpie;
        mstatus_val[3]     = mstatus_mie;
        mip_val            = '0;
        mip_val[11]        = mip_q[2];
        mip_val[7]         = mip_q[1];
        mip_val[3]         = mip_q[0];
    end

    always_comb begin
        hit       = 1'b1;
        read_only = 1'b0;
        rd_val    = '0;
        case (csr_addr)
            12'h300: rd_val = mstatus_val;
            12'h301: begin rd_val = MISA; read_only = 1'b1; end
            12'h304: rd_val = mie_reg;
            12'h305: rd_val = {mtvec_base, 1'b0, mtvec_mode};
            12'h340: rd_val = mscratch;
            12'h341: rd_val = mepc;
            12'h342: rd_val = mcause;
            12'h343: rd_val = mtval;
            12'h344: begin rd_val = mip_val; read_only = 1'b1; end
            12'hB00: begin hit = CNT_EN; rd_val = mcycle[31:0];    end
            12'hB02: begin hit = CNT_EN; rd_val = minstret[31:0];  end
            12'hB80: begin hit = CNT_EN; rd_val = mcycle[63:32];   end
            12'hB82: begin hit = CNT_EN; rd_val = minstret[63:32]; end
            default: hit = 1'b0;
        endcase
    end

    // RS/RC with a zero operand is a pure read, so it is legal even on read-only registers.
    assign csr_illegal = (csr_op != 2'b00) &&
                         (!hit || (read_only && (csr_op == OP_RW || csr_w_data != '0)));
    assign csr_r_data  = csr_illegal ? '0 : rd_val;

    always_comb begin
        case (csr_op)
            OP_RW:   wr_val = csr_w_data;
            OP_RS:   wr_val = rd_val | csr_w_data;
            OP_RC:   wr_val = rd_val & ~csr_w_data;
            default: wr_val = rd_val;
        endcase
    end

    assign wr_en = (csr_op != 2'b00) && !csr_illegal && !read_only && !trap_en && !mret_en;

    // A written half replaces its increment; the other half keeps the carry from the old value.
    always_comb begin
        mcycle_next   = mcycle + 64'd1;
        minstret_next = minstret + {63'd0, instr_retire};
        if (wr_en) begin
            case (csr_addr)
                12'hB00: mcycle_next[31:0]    = wr_val;
                12'hB80: mcycle_next[63:32]   = wr_val;
                12'hB02: minstret_next[31:0]  = wr_val;
                12'hB82: minstret_next[63:32] = wr_val;
                default: ;
            endcase
        end
        if (!CNT_EN) begin
            mcycle_next   = '0;
            minstret_next = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            mstatus_mie  <= 1'b0;
            mstatus_mpie <= 1'b0;
            mie_reg      <= '0;
            mscratch     <= '0;
            mepc         <= '0;
            mcause       <= '0;
            mtval        <= '0;
            mtvec_base   <= MTVEC_RESET[XLEN-1:2];
            mtvec_mode   <= RST_MODE;
            mip_q        <= '0;
            mcycle       <= '0;
            minstret     <= '0;
        end else begin
            mip_q    <= {irq_ext, irq_timer, irq_soft};
            mcycle   <= mcycle_next;
            minstret <= minstret_next;
            if (trap_en) begin
                mepc         <= trap_pc & ~XLEN'(3);
                mcause       <= trap_cause;
                mtval        <= trap_val;
                mstatus_mpie <= mstatus_mie;
                mstatus_mie  <= 1'b0;
            end else if (mret_en) begin
                mstatus_mie  <= mstatus_mpie;
                mstatus_mpie <= 1'b1;
            end else if (wr_en) begin
                case (csr_addr)
                    12'h300: begin
                        mstatus_mie  <= wr_val[3];
                        mstatus_mpie <= wr_val[7];
                    end
                    12'h304: mie_reg <= wr_val & MIE_MASK;
                    12'h305: begin
                        mtvec_base <= wr_val[XLEN-1:2];
                        // Only MODE 0/1 are legal; other encodings leave the mode alone.
                        if (!wr_val[1]) mtvec_mode <= wr_val[0] && VEC_EN;
                    end
                    12'h340: mscratch <= wr_val;
                    12'h341: mepc     <= wr_val & ~XLEN'(3);
                    12'h342: mcause   <= wr_val;
                    12'h343: mtval    <= wr_val;
                    default: ;
                endcase
            end
        end
    end

    assign trap_vector = {mtvec_base, 2'b00} +
                         ((mtvec_mode && VEC_EN && trap_cause[XLEN-1]) ?
                          XLEN'({trap_cause[4:0], 2'b00}) : '0);
    assign mepc_out    = mepc;
    assign irq_pending = mstatus_mie && |(mip_val & mie_reg);
endmodule

// File: tb/tb_csr_file_m.sv
// tb/tb_csr_file_m.sv - directed self-checking bench for csr_file_m
module tb_csr_file_m;
    logic        clock = 1'b0;
    logic        reset_n;
    logic [11:0] csr_addr;
    logic [1:0]  csr_op;
    logic [31:0] csr_w_data, csr_r_data;
    logic        csr_illegal, instr_retire, trap_en, mret_en;
    logic [31:0] trap_cause, trap_pc, trap_val, trap_vector, mepc_out;
    logic        irq_ext, irq_timer, irq_soft, irq_pending;

    int n_checks = 0;
    int n_pass   = 0;

    csr_file_m dut (
        .clock(clock), .reset_n(reset_n),
        .csr_addr(csr_addr), .csr_op(csr_op), .csr_w_data(csr_w_data),
        .csr_r_data(csr_r_data), .csr_illegal(csr_illegal),
        .instr_retire(instr_retire), .trap_en(trap_en), .trap_cause(trap_cause),
        .trap_pc(trap_pc), .trap_val(trap_val), .mret_en(mret_en),
        .irq_ext(irq_ext), .irq_timer(irq_timer), .irq_soft(irq_soft),
        .trap_vector(trap_vector), .mepc_out(mepc_out), .irq_pending(irq_pending)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic rd(input string tag, input logic [11:0] addr, input logic [31:0] exp);
        csr_op   = 2'b00;
        csr_addr = addr;
        #1;
        check(tag, csr_r_data, exp);
    endtask

    task automatic wr(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] data);
        csr_op     = op;
        csr_addr   = addr;
        csr_w_data = data;
        tick();
        csr_op     = 2'b00;
    endtask

    initial begin
        reset_n = 1'b0; csr_addr = '0; csr_op = '0; csr_w_data = '0;
        instr_retire = 0; trap_en = 0; mret_en = 0;
        trap_cause = '0; trap_pc = '0; trap_val = '0;
        irq_ext = 0; irq_timer = 0; irq_soft = 0;
        tick(); tick();
        reset_n = 1'b1;

        rd("rst_mtvec", 12'h305, 32'h0);
        rd("rst_misa", 12'h301, 32'h4000_0100);
        rd("rst_mstatus", 12'h300, 32'h0000_1800);
        check("rst_mepc_out", mepc_out, 32'h0);
        check("rst_irq_pending", {31'd0, irq_pending}, 32'h0);
        check("rst_trap_vector", trap_vector, 32'h0);

        wr(2'b01, 12'h300, 32'hFFFF_FFFF);
        rd("mstatus_rw", 12'h300, 32'h0000_1888);
        wr(2'b11, 12'h300, 32'h8);
        rd("mstatus_rc", 12'h300, 32'h0000_1880);
        wr(2'b10, 12'h300, 32'h8);
        rd("mstatus_rs", 12'h300, 32'h0000_1888);

        wr(2'b01, 12'h305, 32'h0000_1001);
        rd("mtvec_rw", 12'h305, 32'h0000_1001);
        trap_cause = 32'h0000_0007; #1;
        check("vec_exception", trap_vector, 32'h0000_1000);
        trap_en = 1; trap_cause = 32'h8000_0007; trap_pc = 32'h0000_0123; trap_val = 32'hDEAD_BEEF;
        #1;
        check("vec_irq", trap_vector, 32'h0000_101C);
        tick();
        trap_en = 0;
        rd("trap_mstatus", 12'h300, 32'h0000_1880);
        check("trap_mepc", mepc_out, 32'h0000_0120);
        rd("trap_mcause", 12'h342, 32'h8000_0007);
        rd("trap_mtval", 12'h343, 32'hDEAD_BEEF);

        mret_en = 1; tick(); mret_en = 0;
        rd("mret_mstatus", 12'h300, 32'h0000_1888);

        trap_en = 1; mret_en = 1; trap_pc = 32'h0000_0206;
        wr(2'b01, 12'h340, 32'h5);
        trap_en = 0; mret_en = 0;
        rd("prio_mscratch", 12'h340, 32'h0);
        rd("prio_mstatus", 12'h300, 32'h0000_1880);
        check("prio_mepc", mepc_out, 32'h0000_0204);

        csr_op = 2'b01; csr_addr = 12'h7C0; csr_w_data = 32'h1; #1;
        check("ill_unlisted", {31'd0, csr_illegal}, 32'h1);
        check("ill_rdata", csr_r_data, 32'h0);
        tick();
        csr_op = 2'b01; csr_addr = 12'h301; #1;
        check("ill_misa_rw", {31'd0, csr_illegal}, 32'h1);
        csr_op = 2'b10; csr_w_data = 32'h0; #1;
        check("misa_rs0_legal", {31'd0, csr_illegal}, 32'h0);
        check("misa_rs0_data", csr_r_data, 32'h4000_0100);
        csr_op = 2'b11; csr_addr = 12'h344; csr_w_data = 32'h1; #1;
        check("ill_mip_rc", {31'd0, csr_illegal}, 32'h1);
        csr_op = 2'b00;
        rd("ill_nochange", 12'h340, 32'h0);

        wr(2'b01, 12'hB00, 32'hFFFF_FFFF);
        rd("mcycle_wr", 12'hB00, 32'hFFFF_FFFF);
        rd("mcycleh_wr", 12'hB80, 32'h0);
        tick();
        rd("mcycle_wrap", 12'hB00, 32'h0);
        rd("mcycleh_carry", 12'hB80, 32'h1);
        rd("minstret_0", 12'hB02, 32'h0);
        for (int i = 0; i < 3; i++) begin
            instr_retire = 1; tick();
            instr_retire = 0; tick();
        end
        rd("minstret_3", 12'hB02, 32'h3);

        wr(2'b01, 12'h304, 32'hFFFF_FFFF);
        rd("mie_mask", 12'h304, 32'h0000_0888);
        wr(2'b01, 12'h304, 32'h0000_0080);
        wr(2'b10, 12'h300, 32'h8);
        irq_timer = 1; #1;
        check("irq_lag0", {31'd0, irq_pending}, 32'h0);
        tick();
        check("irq_lag1", {31'd0, irq_pending}, 32'h1);
        rd("mip_timer", 12'h344, 32'h0000_0080);

        reset_n = 0;
        wr(2'b01, 12'h340, 32'h7);
        reset_n = 1;
        rd("mid_rst_mscratch", 12'h340, 32'h0);
        rd("mid_rst_mtvec", 12'h305, 32'h0);
        rd("mid_rst_mcycle", 12'hB00, 32'h0);
        check("mid_rst_irq", {31'd0, irq_pending}, 32'h0);
        check("mid_rst_mepc", mepc_out, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/csr_file_m.md
# csr_file_m

Parametrised machine-mode CSR file for the core, replacing the fixed eight-entry register array. It handles read/write/set/clear CSR operations with combinational read-back and per-register write masks. It also provides trap entry and `mret` sequencing, interrupt pending/enable gating, and 64-bit `mcycle`/`minstret` counters. It sits beside the decode/execute stage and feeds the trap vector and `mepc` to the PC-select logic.

## Interface
- `XLEN`, 32: register width, 32 only in this revision.
- `HAS_COUNTERS`, 1: 1 implements `mcycle`/`minstret` and their `h` halves; 0 makes them read 0 and flags access illegal.
- `MTVEC_RESET`, 32'h0000_0000: reset value of `mtvec`.
- `VECTORED_EN`, 1: 1 honours `mtvec.MODE`=1 for interrupts; 0 forces MODE to 0.

- `clock`  in  1  rising-edge clock.
- `reset_n`  in  1  synchronous, active-low reset.
- `csr_addr`  in  12  CSR address.
- `csr_op`  in  2  operation: 00 none, 01 RW, 10 RS (set), 11 RC (clear).
- `csr_w_data`  in  XLEN  operand (rs1 value or zimm).
- `csr_r_data`  out  XLEN  current value at `csr_addr`, combinational.
- `csr_illegal`  out  1  address unimplemented, or write to read-only, while `csr_op`≠0.
- `instr_retire`  in  1  one instruction retired this cycle.
- `trap_en`  in  1  take trap this cycle.
- `trap_cause`  in  XLEN  mcause value; bit 31 set means interrupt.
- `trap_pc`  in  XLEN  PC saved to `mepc`.
- `trap_val`  in  XLEN  value saved to `mtval`.
- `mret_en`  in  1  execute `mret` this cycle.
- `irq_ext`, `irq_timer`, `irq_soft`  in  1 each  level interrupt lines.
- `trap_vector`  out  XLEN  target PC for the trap presented this cycle.
- `mepc_out`  out  XLEN  `mepc`, for the `mret` target.
- `irq_pending`  out  1  `mstatus.MIE` & |(`mip` & `mie`).

## Operation

**Register map and write masks**
- `mstatus` 0x300: bit 3 MIE and bit 7 MPIE are writable; MPP bits 12:11 read as 2'b11; all other bits read 0.
- `misa` 0x301: read-only, value 32'h4000_0100 (RV32I).
- `mie` 0x304: bits 3, 7, 11 writable.
- `mtvec` 0x305: bits 31:2 are BASE; bits 1:0 are MODE, and only values 0 and 1 are stored.
- `mscratch` 0x340: full width.
- `mepc` 0x341: bits 1:0 forced to 0.
- `mcause` 0x342: full width.
- `mtval` 0x343: full width.
- `mip` 0x344: read-only; bits 3, 7, 11 reflect `irq_soft`, `irq_timer`, `irq_ext` registered one cycle.
- Counters: `mcycle` 0xB00, `minstret` 0xB02, `mcycleh` 0xB80, `minstreth` 0xB82.

**CSR operations**
- New value = RW: `w`; RS: `old|w`; RC: `old&~w`. The result is masked before storing.
- RS/RC with `w`=0 still count as an access.
- On an illegal access, no state changes and `csr_r_data` = 0.
- `csr_illegal` is asserted for:
  - any unlisted address;
  - `misa`/`mip` with RW;
  - RS/RC with `w`≠0 to `misa`/`mip`;
  - counter addresses when `HAS_COUNTERS`=0.

**Counters**
- `mcycle` increments every cycle out of reset.
- `minstret` increments when `instr_retire`=1.
- Both are 64-bit and wrap from all-ones to 0.

**Trap entry** (`trap_en`=1), all updates at the next edge:
- `mepc`←`trap_pc` & ~3.
- `mcause`←`trap_cause`.
- `mtval`←`trap_val`.
- MPIE←MIE, then MIE←0.

**`mret`** (`mret_en`=1): MIE←MPIE, MPIE←1.

**`trap_vector`**
- Equals BASE<<2.
- Exception: if MODE=1, `VECTORED_EN`=1 and `trap_cause`[31]=1, it is BASE<<2 + 4×`trap_cause`[4:0].

**Priority within one cycle**
- `trap_en` beats `mret_en`, which beats the CSR write. The losing CSR write is discarded entirely.
- A CSR write to a counter half beats that half's increment. The other half still increments, with carry computed from the pre-write value.

## Timing
- Reads are combinational from current state, so a write is visible on the cycle after its edge. There is no read-during-write bypass.
- `trap_vector` and `irq_pending` are combinational from current state plus inputs.
- `mip` lags the interrupt lines by 1 cycle, so `irq_pending` lags them by 1 cycle.
- Reset (`reset_n`=0 at an edge, including mid-operation):
  - All registers are 0, except `mtvec`=`MTVEC_RESET` and the `mstatus` MPP read-value.
  - Counters are 0.
  - The `mip` register is 0.
  - Outputs after reset: `csr_r_data` per address, `irq_pending`=0, `mepc_out`=0, `trap_vector`=`MTVEC_RESET`&~3 when MODE=0.
- Reset overrides a coincident trap, `mret` or write.

## Test plan
- Reset, then read 0x305 and 0x301 → 32'h0 and 32'h4000_0100.
- RW 0x300←32'hFFFF_FFFF, then read back → 32'h0000_1888. RC with 32'h8 → 32'h0000_1880.
- `mtvec`=32'h0000_1001 (vectored), `trap_en` with cause 32'h8000_0007 and PC 32'h0000_0123 → `trap_vector`=32'h0000_101C. Next cycle: `mepc`=32'h0000_0120, MIE=0, MPIE=old MIE. Then `mret` → MIE restored.
- `trap_en`, `mret_en` and RW 0x340←5 in the same cycle → trap effects only; `mscratch` unchanged.
- Write `mcycle`←32'hFFFF_FFFF, then run 2 cycles → `mcycleh` increments by 1 and `mcycle`=0 after the wrap. Pulse `instr_retire` 3 times → `minstret`=3.
- MIE=1, `mie`[7]=1, raise `irq_timer` → `irq_pending`=1 exactly 1 cycle later. Access 0x7C0 → `csr_illegal`=1 and no state change.
